rv32im_mem_arb: RTL and testbench
=================================

# rv32im_mem_arb

Single-port memory arbiter that shares one data/instruction memory port between the instruction fetch unit (IFU) and the load/store unit (`rv32im_lsu`). It accepts one request per requester, grants by fixed LSU priority with an IFU anti-starvation override, and issues one transaction at a time to a variable-latency memory. It tracks the single outstanding access, returns the response to the owning requester, and raises an error on a response timeout.

## Interface
- `STARVE_LIMIT`, 4: consecutive LSU grants with IFU pending before IFU is forced to win; range 1–15.
- `TIMEOUT_CYCLES`, 255: WAIT cycles without `mem_rvalid_i` before the access is aborted with error; range 1–255.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `ifu_req_i`  in  1  IFU read request; held high until `ifu_rvalid_o`.
- `ifu_addr_i`  in  `API_DATA_WIDTH`  fetch address; bits [1:0] ignored.
- `ifu_rvalid_o`  out  1  one-cycle response strobe.
- `ifu_rdata_o`  out  `API_DATA_WIDTH`  fetched word; 0 when `ifu_rvalid_o` low.
- `ifu_err_o`  out  1  timeout flag, valid with `ifu_rvalid_o`.
- `lsu_req_i`  in  1  LSU request; held high with stable payload until `lsu_rvalid_o`.
- `lsu_we_i`  in  1  1 = store, 0 = load.
- `lsu_addr_i`  in  `API_DATA_WIDTH`  word address from LSU `addr_mem_o`.
- `lsu_wdata_i`  in  `API_DATA_WIDTH`  store data (LSU `val_memwr_o`).
- `lsu_wr_mask_i`  in  4  byte write mask (LSU `wr_mask_o`).
- `lsu_rvalid_o`  out  1  one-cycle response strobe (load data or store ack).
- `lsu_rdata_o`  out  `API_DATA_WIDTH`  load word; 0 for stores and when strobe low.
- `lsu_err_o`  out  1  timeout flag, valid with `lsu_rvalid_o`.
- `mem_req_o`  out  1  one-cycle issue strobe.
- `mem_we_o`  out  1  write enable, registered.
- `mem_addr_o`  out  `API_DATA_WIDTH`  registered address.
- `mem_wdata_o`  out  `API_DATA_WIDTH`  registered write data.
- `mem_wr_mask_o`  out  4  registered byte mask; 0 for reads.
- `mem_rdata_i`  in  `API_DATA_WIDTH`  read data, valid with `mem_rvalid_i`.
- `mem_rvalid_i`  in  1  response strobe for reads and writes.
- `busy_o`  out  1  high in ISSUE and WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any request is pending, capture the winner's payload into the `mem_*` registers and latch `owner` (IFU/LSU) → ISSUE. Otherwise stay in IDLE.
- Grant rule: LSU wins when both are pending, unless `starve_cnt == STARVE_LIMIT`; then IFU wins.
- `starve_cnt`: increments on an LSU grant while `ifu_req_i` is high. Clears on an IFU grant or whenever `ifu_req_i` is low in IDLE. Saturates at `STARVE_LIMIT`.
- IFU capture: `mem_we_o=0`, `mem_wr_mask_o=0`, `mem_wdata_o=0`, `mem_addr_o={ifu_addr_i[31:2],2'b00}`.
- ISSUE: `mem_req_o=1` for exactly this cycle → WAIT; clear `to_cnt`.
- WAIT: on `mem_rvalid_i`, assert the owner's `*_rvalid_o` combinationally in the same cycle and forward `mem_rdata_i` if the access is a read → IDLE. Without `mem_rvalid_i`, increment `to_cnt`.
- Timeout: when `to_cnt == TIMEOUT_CYCLES`, pulse the owner's `*_rvalid_o` with `*_err_o=1` and rdata 0 → IDLE. The memory must not respond after a timeout; a late response is undefined.
- `mem_rvalid_i` is ignored in IDLE and ISSUE.
- The non-owner's outputs stay 0 throughout a transaction.
- A requester still holding `req_i` in the cycle after its `rvalid_o` is treated as a new request.

## Timing
- Reset (asynchronous, mid-transaction included): state=IDLE, counters=0, owner=IFU. All outputs are 0. Any pending access is abandoned with no response.
- Minimum latency: request seen in IDLE at cycle n; `mem_req_o` at n+1; earliest `rvalid_o` at n+2 (memory responds in the first WAIT cycle).
- Throughput: at most one access per 3 cycles.
- The `mem_*` payload stays stable from ISSUE until the exit from WAIT.
- Requests dropped before their response are a protocol violation; the arbiter still completes the access to the latched owner.

## Structure
- Width macros come from the shared defines header already used by `rv32im_lsu`: `API_DATA_WIDTH`, plus new `MEM_ARB_ST_IDLE/ISSUE/WAIT` (2-bit) and `MEM_ARB_OWNER_IFU/LSU` (1-bit).
- One sub-module, `rv32im_mem_arb_prio`: combinational grant decision plus the `starve_cnt` register. FSM, payload registers and timeout counter live in the top module.

## Test plan
- LSU load only: `lsu_addr_i=32'h10`, memory answers 1 cycle after `mem_req_o` with `32'h08439341` → `lsu_rvalid_o` at n+2, `lsu_rdata_o=32'h08439341`, `ifu_rvalid_o` stays 0.
- Store: `lsu_we_i=1`, `lsu_wr_mask_i=4'b0011`, `lsu_wdata_i=32'h00009341` → `mem_we_o=1`, mask 0011 stable through WAIT, ack gives `lsu_rdata_o=0`.
- Contention with `STARVE_LIMIT=4`, both requests held continuously → grant order LSU×4, IFU, LSU×4, IFU. IFU `mem_addr_o` has [1:0]=00 for `ifu_addr_i=32'h103`.
- Timeout with `TIMEOUT_CYCLES=8`, memory silent → `ifu_rvalid_o=1`, `ifu_err_o=1`, rdata 0, 9 cycles after ISSUE. The next request then issues normally.
- Reset asserted in WAIT → all outputs 0 immediately (asynchronous); after release, state is IDLE and no stale `rvalid_o` is seen.
- `mem_rvalid_i` pulsed in IDLE and in ISSUE → ignored; no `rvalid_o` until WAIT.

Source files
------------

// File: rtl/rv32im_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// rv32im_mem_arb_pkg: widths and encodings shared by the memory arbiter. Rev 1.0
// ============================================================================
package rv32im_mem_arb_pkg;

  localparam int API_DATA_WIDTH = 32;
  localparam int TO_CNT_W       = 8;
  localparam int STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    MEM_ARB_ST_IDLE  = 2'd0,
    MEM_ARB_ST_ISSUE = 2'd1,
    MEM_ARB_ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    MEM_ARB_OWNER_IFU = 1'b0,
    MEM_ARB_OWNER_LSU = 1'b1
  } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/rv32im_mem_arb_prio.sv
`default_nettype none
// ============================================================================
// rv32im_mem_arb_prio: LSU-first grant with IFU anti-starvation counter. Rev 1.0
// ============================================================================
module rv32im_mem_arb_prio
  import rv32im_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idle,
  input  logic       ifu_req,
  input  logic       lsu_req,
  output logic       grant,
  output arb_owner_t grant_owner
);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    starved;

  always_comb begin
    starved     = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));
    grant       = idle && (ifu_req || lsu_req);
    grant_owner = (lsu_req && !(ifu_req && starved)) ? MEM_ARB_OWNER_LSU
                                                     : MEM_ARB_OWNER_IFU;
  end

  // An LSU win with IFU waiting only happens below the limit, so the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (!ifu_req || grant_owner == MEM_ARB_OWNER_IFU) begin
        starve_cnt <= '0;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rv32im_mem_arb.sv
`default_nettype none
// ============================================================================
// rv32im_mem_arb: shares one memory port between IFU and LSU, one access at a time. Rev 1.0
// ============================================================================
module rv32im_mem_arb
  import rv32im_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      ifu_req_i,
  input  logic [API_DATA_WIDTH-1:0] ifu_addr_i,
  output logic                      ifu_rvalid_o,
  output logic [API_DATA_WIDTH-1:0] ifu_rdata_o,
  output logic                      ifu_err_o,
  input  logic                      lsu_req_i,
  input  logic                      lsu_we_i,
  input  logic [API_DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [API_DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [3:0]                lsu_wr_mask_i,
  output logic                      lsu_rvalid_o,
  output logic [API_DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                      lsu_err_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [API_DATA_WIDTH-1:0] mem_addr_o,
  output logic [API_DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]                mem_wr_mask_o,
  input  logic [API_DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                      mem_rvalid_i,
  output logic                      busy_o
);

  arb_state_t          state, state_next;
  arb_owner_t          owner, grant_owner;
  logic                grant, idle, resp, timeout;
  logic [TO_CNT_W-1:0] to_cnt;
  logic                unused_ifu_lsb;

  assign unused_ifu_lsb = ^ifu_addr_i[1:0];
  assign idle           = (state == MEM_ARB_ST_IDLE);

  rv32im_mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .idle       (idle),
    .ifu_req    (ifu_req_i),
    .lsu_req    (lsu_req_i),
    .grant      (grant),
    .grant_owner(grant_owner)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= MEM_ARB_ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_req_o  = 1'b0;
    busy_o     = 1'b0;
    resp       = 1'b0;
    timeout    = 1'b0;
    case (state)
      MEM_ARB_ST_IDLE: begin
        if (grant) state_next = MEM_ARB_ST_ISSUE;
      end
      MEM_ARB_ST_ISSUE: begin
        mem_req_o  = 1'b1;
        busy_o     = 1'b1;
        state_next = MEM_ARB_ST_WAIT;
      end
      MEM_ARB_ST_WAIT: begin
        busy_o  = 1'b1;
        resp    = mem_rvalid_i;
        timeout = !mem_rvalid_i && (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES));
        if (resp || timeout) state_next = MEM_ARB_ST_IDLE;
      end
      default: state_next = MEM_ARB_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner         <= MEM_ARB_OWNER_IFU;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_wr_mask_o <= '0;
      to_cnt        <= '0;
    end else begin
      if (grant) begin
        owner <= grant_owner;
        if (grant_owner == MEM_ARB_OWNER_LSU) begin
          mem_we_o      <= lsu_we_i;
          mem_addr_o    <= lsu_addr_i;
          mem_wdata_o   <= lsu_wdata_i;
          mem_wr_mask_o <= lsu_we_i ? lsu_wr_mask_i : 4'b0000;
        end else begin
          mem_we_o      <= 1'b0;
          mem_addr_o    <= {ifu_addr_i[API_DATA_WIDTH-1:2], 2'b00};
          mem_wdata_o   <= '0;
          mem_wr_mask_o <= 4'b0000;
        end
      end
      if (state == MEM_ARB_ST_ISSUE) begin
        to_cnt <= '0;
      end else if (state == MEM_ARB_ST_WAIT && !resp && !timeout) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Response strobes exist only in WAIT; the non-owner side stays quiet.
  always_comb begin
    ifu_rvalid_o = (resp || timeout) && (owner == MEM_ARB_OWNER_IFU);
    lsu_rvalid_o = (resp || timeout) && (owner == MEM_ARB_OWNER_LSU);
    ifu_err_o    = timeout && (owner == MEM_ARB_OWNER_IFU);
    lsu_err_o    = timeout && (owner == MEM_ARB_OWNER_LSU);
    ifu_rdata_o  = (resp && owner == MEM_ARB_OWNER_IFU) ? mem_rdata_i : '0;
    lsu_rdata_o  = (resp && owner == MEM_ARB_OWNER_LSU && !mem_we_o) ? mem_rdata_i : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32im_mem_arb.sv
`default_nettype none
// ============================================================================
// tb_rv32im_mem_arb: directed and randomized checks of the IFU/LSU memory arbiter. Rev 1.0
// ============================================================================
module tb_rv32im_mem_arb;

  localparam int LIMIT = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_i = 1'b0;
  logic [31:0] ifu_addr_i = '0;
  logic        ifu_rvalid_o, ifu_err_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
  logic [3:0]  lsu_wr_mask_i = '0;
  logic        lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o, busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wr_mask_o;
  logic        mem_rvalid_i;

  logic        poke_rv = 1'b0, resp_rv = 1'b0;
  logic [31:0] resp_rd = '0;
  assign mem_rvalid_i = poke_rv | resp_rv;
  assign mem_rdata_i  = resp_rd;

  int          errors = 0, checks = 0;
  logic [31:0] phys_mem [16];
  logic [31:0] ref_mem  [16];
  int          fixed_lat = 1;
  bit          mem_silent = 1'b0;
  int          cd = 0;
  logic [31:0] cur_addr, cur_wdata;
  logic        cur_we;
  logic [3:0]  cur_mask;

  // scratch state for the directed and random phases
  logic [31:0] v, old_word, exp_ifu_data, exp_lsu_data;
  logic [3:0]  idx;
  int          ngrant, nresp, streak, done_cnt;
  bit          exp_lsu, p_ifu, p_lsu, ifu_act, lsu_act, ifu_granted, lsu_granted;
  bit          ifu_fin, lsu_fin, win_lsu;

  always #5 clk = ~clk;

  rv32im_mem_arb #(.STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_rvalid_o(ifu_rvalid_o),
    .ifu_rdata_o(ifu_rdata_o), .ifu_err_o(ifu_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wr_mask_i(lsu_wr_mask_i), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wr_mask_o(mem_wr_mask_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .busy_o(busy_o)
  );

  // Memory model: answers fixed_lat cycles after the issue strobe (random 1..4 when 0).
  always @(posedge clk) begin
    #1;
    resp_rv = 1'b0;
    resp_rd = '0;
    if (!rst_n) begin
      cd = 0;
    end else if (mem_req_o) begin
      cd        = mem_silent ? 0 : (fixed_lat > 0 ? fixed_lat : int'($urandom_range(4, 1)));
      cur_addr  = mem_addr_o;
      cur_we    = mem_we_o;
      cur_wdata = mem_wdata_o;
      cur_mask  = mem_wr_mask_o;
    end else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        resp_rv = 1'b1;
        if (cur_we) begin
          for (int b = 0; b < 4; b++)
            if (cur_mask[b]) phys_mem[cur_addr[5:2]][8*b +: 8] = cur_wdata[8*b +: 8];
        end else begin
          resp_rd = phys_mem[cur_addr[5:2]];
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) phys_mem[i] = $urandom;

    // reset state
    #12;
    chk1("rst_mem_req", mem_req_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_ifu_rvalid", ifu_rvalid_o, 1'b0);
    chk1("rst_lsu_rvalid", lsu_rvalid_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // LSU load, minimum latency
    phys_mem[4] = 32'h08439341;
    fixed_lat   = 1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h10;
    tick();
    chk1("ld_issue", mem_req_o, 1'b1);
    chk("ld_addr", mem_addr_o, 32'h10);
    chk1("ld_we", mem_we_o, 1'b0);
    chk1("ld_early_rvalid", lsu_rvalid_o, 1'b0);
    tick();
    chk1("ld_rvalid", lsu_rvalid_o, 1'b1);
    chk("ld_rdata", lsu_rdata_o, 32'h08439341);
    chk1("ld_ifu_quiet", ifu_rvalid_o, 1'b0);
    lsu_req_i = 1'b0;
    tick();
    chk1("ld_idle", busy_o, 1'b0);

    // store with 3-cycle memory latency
    fixed_lat = 3;
    old_word  = phys_mem[8];
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h20;
    lsu_wdata_i = 32'h00009341; lsu_wr_mask_i = 4'b0011;
    tick();
    chk1("st_issue", mem_req_o, 1'b1);
    chk1("st_we", mem_we_o, 1'b1);
    chk("st_wdata", mem_wdata_o, 32'h00009341);
    chk("st_mask0", {28'h0, mem_wr_mask_o}, 32'h3);
    tick();
    chk1("st_req_once", mem_req_o, 1'b0);
    chk("st_mask1", {28'h0, mem_wr_mask_o}, 32'h3);
    tick();
    chk("st_mask2", {28'h0, mem_wr_mask_o}, 32'h3);
    chk1("st_no_rvalid", lsu_rvalid_o, 1'b0);
    tick();
    chk1("st_ack", lsu_rvalid_o, 1'b1);
    chk("st_ack_rdata", lsu_rdata_o, 32'h0);
    chk("st_mask3", {28'h0, mem_wr_mask_o}, 32'h3);
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_wr_mask_i = 4'b0000;
    tick();
    chk("st_mem_word", phys_mem[8], {old_word[31:16], 16'h9341});

    // contention: LSUx4, IFU, LSUx4, IFU
    fixed_lat = 1;
    lsu_addr_i = 32'h10; ifu_addr_i = 32'h103;
    ifu_req_i = 1'b1; lsu_req_i = 1'b1;
    ngrant = 0; nresp = 0;
    for (int cyc = 0; cyc < 60 && nresp < 10; cyc++) begin
      tick();
      if (mem_req_o) begin
        exp_lsu = (ngrant % 5) != 4;
        chk("arb_grant_addr", mem_addr_o, exp_lsu ? 32'h10 : 32'h100);
        ngrant++;
      end
      if (ifu_rvalid_o) chk("arb_ifu_rdata", ifu_rdata_o, phys_mem[0]);
      if (ifu_rvalid_o || lsu_rvalid_o) nresp++;
    end
    ifu_req_i = 1'b0; lsu_req_i = 1'b0;
    chk("arb_resp_count", 32'(nresp), 32'd10);

    // timeout with a silent memory, then a normal access
    tick();
    mem_silent = 1'b1;
    ifu_req_i = 1'b1; ifu_addr_i = 32'h40;
    tick();
    chk1("to_issue", mem_req_o, 1'b1);
    for (int i = 0; i < TMO; i++) begin
      tick();
      chk1("to_quiet", ifu_rvalid_o, 1'b0);
    end
    tick();
    chk1("to_rvalid", ifu_rvalid_o, 1'b1);
    chk1("to_err", ifu_err_o, 1'b1);
    chk("to_rdata", ifu_rdata_o, 32'h0);
    chk1("to_lsu_quiet", lsu_rvalid_o, 1'b0);
    ifu_req_i = 1'b0; mem_silent = 1'b0;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h10;
    tick();
    chk1("to_back_idle", busy_o, 1'b0);
    tick();
    chk1("to_next_issue", mem_req_o, 1'b1);
    tick();
    chk1("to_next_rvalid", lsu_rvalid_o, 1'b1);
    chk1("to_next_err", lsu_err_o, 1'b0);
    chk("to_next_rdata", lsu_rdata_o, 32'h08439341);
    lsu_req_i = 1'b0;

    // asynchronous reset during WAIT
    tick();
    mem_silent = 1'b1;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h10;
    tick();
    tick();
    chk1("rw_busy", busy_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("rw_busy0", busy_o, 1'b0);
    chk1("rw_req0", mem_req_o, 1'b0);
    chk("rw_addr0", mem_addr_o, 32'h0);
    chk1("rw_rvalid0", lsu_rvalid_o, 1'b0);
    lsu_req_i = 1'b0; mem_silent = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("rw_no_stale", lsu_rvalid_o | ifu_rvalid_o | busy_o, 1'b0);
    end

    // mem_rvalid_i pulses in IDLE and ISSUE are ignored
    fixed_lat = 2;
    poke_rv = 1'b1;
    lsu_req_i = 1'b1; lsu_addr_i = 32'h10;
    #1;
    chk1("pk_idle", lsu_rvalid_o | ifu_rvalid_o, 1'b0);
    tick();
    chk1("pk_issue_req", mem_req_o, 1'b1);
    chk1("pk_issue", lsu_rvalid_o, 1'b0);
    poke_rv = 1'b0;
    tick();
    chk1("pk_wait1", lsu_rvalid_o, 1'b0);
    tick();
    chk1("pk_resp", lsu_rvalid_o, 1'b1);
    chk("pk_rdata", lsu_rdata_o, 32'h08439341);
    lsu_req_i = 1'b0;
    tick();

    // randomized traffic against a grant-order reference model
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      phys_mem[i] = v;
      ref_mem[i]  = v;
    end
    fixed_lat = 0;
    streak = 0; done_cnt = 0;
    p_ifu = 0; p_lsu = 0; ifu_act = 0; lsu_act = 0; ifu_granted = 0; lsu_granted = 0;
    for (int cyc = 0; cyc < 3000 && done_cnt < 80; cyc++) begin
      tick();
      ifu_fin = 0; lsu_fin = 0;
      if (mem_req_o) begin
        if (!(p_ifu || p_lsu)) begin
          chk1("rnd_spurious_issue", mem_req_o, 1'b0);
        end else begin
          if (p_ifu && (!p_lsu || streak == LIMIT)) begin
            win_lsu = 0; streak = 0;
          end else begin
            win_lsu = 1; streak = p_ifu ? streak + 1 : 0;
          end
          if (win_lsu) begin
            chk("rnd_lsu_addr", mem_addr_o, lsu_addr_i);
            chk1("rnd_lsu_we", mem_we_o, lsu_we_i);
            chk("rnd_lsu_mask", {28'h0, mem_wr_mask_o}, {28'h0, lsu_we_i ? lsu_wr_mask_i : 4'h0});
            idx = lsu_addr_i[5:2];
            if (lsu_we_i) begin
              for (int b = 0; b < 4; b++)
                if (lsu_wr_mask_i[b]) ref_mem[idx][8*b +: 8] = lsu_wdata_i[8*b +: 8];
              exp_lsu_data = '0;
            end else begin
              exp_lsu_data = ref_mem[idx];
            end
            lsu_granted = 1;
          end else begin
            chk("rnd_ifu_addr", mem_addr_o, {ifu_addr_i[31:2], 2'b00});
            chk1("rnd_ifu_we", mem_we_o, 1'b0);
            exp_ifu_data = ref_mem[ifu_addr_i[5:2]];
            ifu_granted = 1;
          end
        end
      end
      if (ifu_rvalid_o) begin
        chk1("rnd_ifu_owner", ifu_granted, 1'b1);
        chk("rnd_ifu_rdata", ifu_rdata_o, exp_ifu_data);
        chk1("rnd_ifu_err", ifu_err_o, 1'b0);
        chk1("rnd_excl", lsu_rvalid_o, 1'b0);
        ifu_granted = 0; ifu_act = 0; ifu_fin = 1; done_cnt++;
      end
      if (lsu_rvalid_o) begin
        chk1("rnd_lsu_owner", lsu_granted, 1'b1);
        chk("rnd_lsu_rdata", lsu_rdata_o, exp_lsu_data);
        chk1("rnd_lsu_err", lsu_err_o, 1'b0);
        lsu_granted = 0; lsu_act = 0; lsu_fin = 1; done_cnt++;
      end
      if (ifu_fin) begin
        ifu_req_i = 1'b0;
      end else if (!ifu_act && $urandom_range(2, 0) == 0) begin
        ifu_act = 1; ifu_req_i = 1'b1;
        ifu_addr_i = $urandom & 32'h0000_003F;
      end
      if (lsu_fin) begin
        lsu_req_i = 1'b0;
      end else if (!lsu_act && $urandom_range(2, 0) == 0) begin
        lsu_act = 1; lsu_req_i = 1'b1;
        lsu_we_i = 1'($urandom_range(1, 0));
        lsu_addr_i = $urandom & 32'h0000_003C;
        lsu_wdata_i = $urandom;
        lsu_wr_mask_i = 4'($urandom_range(15, 1));
      end
      p_ifu = ifu_req_i;
      p_lsu = lsu_req_i;
    end
    ifu_req_i = 1'b0; lsu_req_i = 1'b0;
    chk1("rnd_all_completed", done_cnt >= 80, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
